up_counter_mod: RTL and testbench



---
 rtl/up_counter_mod_pkg.sv | 15 +
 rtl/up_counter_mod_reg_sync_en.sv | 21 ++
 rtl/up_counter_mod.sv | 83 ++++++++
 tb/tb_up_counter_mod.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/up_counter_mod_pkg.sv
// Shared defaults and helpers for the modulo up-counter.
// The terminal-value helper keeps the MODULUS-1 arithmetic in one place.
package up_counter_mod_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 16;

    // Terminal value MODULUS-1, truncated to the counter width.
    function automatic logic [31:0] terminal_value(input int width, input int modulus);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return 32'(modulus - 1) & mask;
    endfunction

endpackage

// File: rtl/up_counter_mod_reg_sync_en.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
module reg_sync_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/up_counter_mod.sv
// Modulo-MODULUS synchronous up-counter with enable, parallel load,
// terminal count, cascade carry and registered wrap / load-error pulses.
module up_counter_mod
    import up_counter_mod_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(terminal_value(WIDTH, MODULUS));
    // One extra bit so MODULUS == 2^WIDTH is representable in the legality compare.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    logic             d_legal;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_next;
    logic             q_en;
    logic             wrap_next;
    logic             load_err_next;

    assign d_legal   = ({1'b0, d} < MOD_EXT);
    assign q_inc     = q + WIDTH'(1);
    assign tc        = (q == TERMINAL);
    assign carry_out = tc & en & ~load;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        q_next        = q;
        q_en          = 1'b0;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (load) begin
            q_en = 1'b1;
            if (d_legal) begin
                q_next = d;
            end else begin
                q_next        = '0;
                load_err_next = 1'b1;
            end
        end else if (en) begin
            q_en = 1'b1;
            if (tc) begin
                q_next    = '0;
                wrap_next = 1'b1;
            end else begin
                q_next = q_inc;
            end
        end
    end

    reg_sync_en #(
        .WIDTH(WIDTH)
    ) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .en    (q_en),
        .d     (q_next),
        .q     (q)
    );

    // Reset has priority, which also suppresses any pulse due in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_next;
            load_err <= load_err_next;
        end
    end

endmodule

// File: tb/tb_up_counter_mod.sv
// Scoreboard bench for up_counter_mod: modulus 16, modulus 10 and a two-stage cascade.
module tb_up_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: MODULUS=16
    logic       r0 = 1'b1, en0 = 1'b0, ld0 = 1'b0;
    logic [3:0] d0 = '0;
    logic [3:0] q0;
    logic       tc0, co0, wr0, le0;

    // Instance 1: MODULUS=10
    logic       r1 = 1'b1, en1 = 1'b0, ld1 = 1'b0;
    logic [3:0] d1 = '0;
    logic [3:0] q1;
    logic       tc1, co1, wr1, le1;

    // Instance 2/3: cascaded MODULUS=16 pair
    logic       rc = 1'b1, enc = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_wr, lo_le;
    logic       hi_tc, hi_co, hi_wr, hi_le;

    up_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .reset(r0), .en(en0), .load(ld0), .d(d0),
        .q(q0), .tc(tc0), .carry_out(co0), .wrap(wr0), .load_err(le0)
    );

    up_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .reset(r1), .en(en1), .load(ld1), .d(d1),
        .q(q1), .tc(tc1), .carry_out(co1), .wrap(wr1), .load_err(le1)
    );

    up_counter_mod #(.WIDTH(4), .MODULUS(16)) dut_lo (
        .clk(clk), .reset(rc), .en(enc), .load(1'b0), .d(4'h0),
        .q(lo_q), .tc(lo_tc), .carry_out(lo_co), .wrap(lo_wr), .load_err(lo_le)
    );

    up_counter_mod #(.WIDTH(4), .MODULUS(16)) dut_hi (
        .clk(clk), .reset(rc), .en(lo_co), .load(1'b0), .d(4'h0),
        .q(hi_q), .tc(hi_tc), .carry_out(hi_co), .wrap(hi_wr), .load_err(hi_le)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] id;
        logic [7:0]  q;
        logic        tc;
        logic        carry;
        logic        wrap;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    // Monitor: compare the oldest expectation on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [11:0] act;
            logic [11:0] want;
            e = sb.pop_front();
            case (e.sel)
                2'd0:    act = {4'h0, q0, tc0, co0, wr0, le0};
                2'd1:    act = {4'h0, q1, tc1, co1, wr1, le1};
                default: act = {hi_q, lo_q, hi_tc, lo_co, hi_wr, hi_le | lo_le};
            endcase
            want = {e.q, e.tc, e.carry, e.wrap, e.err};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL dut%0d vec%0d: got q=%h tc=%b carry=%b wrap=%b err=%b, expected q=%h tc=%b carry=%b wrap=%b err=%b",
                         e.sel, e.id, act[11:4], act[3], act[2], act[1], act[0],
                         e.q, e.tc, e.carry, e.wrap, e.err);
            end
        end
    end

    // One cycle of stimulus: drive inputs for this cycle and queue the values
    // expected during it (q/wrap/err are current state, tc/carry follow q and inputs).
    task automatic step(input int sel, input logic rst, input logic e, input logic ld,
                        input logic [3:0] dv, input logic [7:0] eq,
                        input logic ew, input logic ee);
        exp_t x;
        @(posedge clk);
        #1;
        case (sel)
            0: begin r0 = rst; en0 = e; ld0 = ld; d0 = dv; end
            1: begin r1 = rst; en1 = e; ld1 = ld; d1 = dv; end
            default: begin rc = rst; enc = e; end
        endcase
        x.sel  = 2'(sel);
        x.id   = 16'(vec_id);
        x.q    = eq;
        x.wrap = ew;
        x.err  = ee;
        case (sel)
            0: begin x.tc = (eq == 8'd15); x.carry = x.tc & e & ~ld; end
            1: begin x.tc = (eq == 8'd9);  x.carry = x.tc & e & ~ld; end
            default: begin x.tc = (eq[7:4] == 4'hF); x.carry = (eq[3:0] == 4'hF) & e; end
        endcase
        sb.push_back(x);
        vec_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);

        // Reset then count through the full 16-state cycle.
        step(0, 1, 0, 0, 4'd0, 8'd0, 0, 0);
        for (int i = 0; i <= 17; i++)
            step(0, 0, 1, 0, 4'd0, 8'(i % 16), (i == 16), 0);
        for (int i = 2; i <= 14; i++)
            step(0, 0, 1, 0, 4'd0, 8'(i), 0, 0);
        // Reset at q=15 with en and load: load ignored, no wrap.
        step(0, 1, 1, 1, 4'd3, 8'd15, 0, 0);
        step(0, 0, 0, 0, 4'd0, 8'd0, 0, 0);
        // Full-range modulus: natural overflow from 15.
        step(0, 0, 0, 1, 4'd15, 8'd0, 0, 0);
        step(0, 0, 1, 0, 4'd0, 8'd15, 0, 0);
        step(0, 0, 0, 0, 4'd0, 8'd0, 1, 0);
        step(0, 0, 0, 0, 4'd0, 8'd0, 0, 0);

        // Short modulus 10.
        step(1, 1, 0, 0, 4'd0, 8'd0, 0, 0);
        for (int i = 0; i <= 10; i++)
            step(1, 0, 1, 0, 4'd0, 8'(i % 10), (i == 10), 0);
        // Load beats enable; illegal load gives q=0 and a one-cycle load_err.
        step(1, 0, 1, 1, 4'd7,  8'd1, 0, 0);
        step(1, 0, 1, 0, 4'd0,  8'd7, 0, 0);
        step(1, 0, 1, 0, 4'd0,  8'd8, 0, 0);
        step(1, 0, 1, 1, 4'd12, 8'd9, 0, 0);
        step(1, 0, 0, 0, 4'd0,  8'd0, 0, 1);
        step(1, 0, 0, 0, 4'd0,  8'd0, 0, 0);
        // Load boundary: d=9 legal, d=10 illegal, legal load clears load_err.
        step(1, 0, 0, 1, 4'd9,  8'd0, 0, 0);
        step(1, 0, 0, 1, 4'd10, 8'd9, 0, 0);
        step(1, 0, 0, 1, 4'd5,  8'd0, 0, 1);
        step(1, 0, 0, 0, 4'd0,  8'd5, 0, 0);
        // Hold at 5, then resume.
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 4'd0, 8'd5, 0, 0);
        step(1, 0, 1, 0, 4'd0, 8'd5, 0, 0);
        step(1, 0, 1, 0, 4'd0, 8'd6, 0, 0);
        step(1, 0, 0, 0, 4'd0, 8'd7, 0, 0);
        // Reset suppresses a due load_err, then a due wrap.
        step(1, 1, 0, 1, 4'd15, 8'd7, 0, 0);
        step(1, 0, 0, 0, 4'd0,  8'd0, 0, 0);
        step(1, 0, 0, 1, 4'd9,  8'd0, 0, 0);
        step(1, 1, 1, 0, 4'd0,  8'd9, 0, 0);
        step(1, 0, 0, 0, 4'd0,  8'd0, 0, 0);

        // Two-stage cascade: 0x00 .. 0xFF, 0x00, 0x01.
        step(2, 1, 0, 0, 4'd0, 8'h00, 0, 0);
        for (int i = 0; i <= 257; i++)
            step(2, 0, 1, 0, 4'd0, 8'(i), (i == 256), 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
